// File: rtl/mod_memstage.sv
// Memory-access stage between execute and writeback: issues load/store/stack accesses over a
// req/ack port and hands exactly one EX_WB record per instruction to writeback.
package mod_memstage_pkg;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [63:0] alu_result;
    logic [63:0] alu_result2;
    logic [7:0]  reg_byte;
    logic [7:0]  rm_byte;
    logic [63:0] pc_contents;
    logic        sim_end;
  } ex_wb_t;
endpackage

module mod_memstage
  import mod_memstage_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  ex_wb_t            ex_wb,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [63:0]       rsp_value,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output ex_wb_t            exwb,
  output logic              can_writeback,
  output logic              store_memstage_active,
  output logic              mem_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t            state_r;
  logic              ex_ready_r;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  ex_wb_t            exwb_r;
  logic              can_wb_r;
  logic              store_act_r;
  logic              mem_err_r;
  logic [7:0]        cnt_r;

  logic              is_mem_s;
  logic              is_we_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wdata_s;
  logic              transfer_s;
  logic [7:0]        cnt_nxt_s;
  logic              timeout_s;

  // flush only gates acceptance; a request already on the bus always runs to completion
  assign transfer_s = ex_valid & ex_ready_r & ~flush;
  assign cnt_nxt_s  = cnt_r + 8'd1;
  assign timeout_s  = (cnt_nxt_s == 8'(TIMEOUT));

  // Classify the offered opcode and form its memory request (stack ops use modulo-2^64 RSP math).
  always_comb begin
    is_mem_s = 1'b0;
    is_we_s  = 1'b0;
    addr_s   = {ADDR_W{1'b0}};
    wdata_s  = {DATA_W{1'b0}};
    case (ex_wb.opcode) inside
      8'h89: begin
        is_mem_s = 1'b1;
        is_we_s  = 1'b1;
        addr_s   = ex_mem_addr;
        wdata_s  = ex_store_data;
      end
      8'h8B: begin
        is_mem_s = 1'b1;
        addr_s   = ex_mem_addr;
      end
      [8'h50:8'h57]: begin
        is_mem_s = 1'b1;
        is_we_s  = 1'b1;
        addr_s   = ADDR_W'(rsp_value - 64'd8);
        wdata_s  = ex_store_data;
      end
      [8'h58:8'h5F]: begin
        is_mem_s = 1'b1;
        addr_s   = ADDR_W'(rsp_value);
      end
      8'hE8, 8'hFF: begin
        is_mem_s = 1'b1;
        is_we_s  = 1'b1;
        addr_s   = ADDR_W'(rsp_value - 64'd8);
        wdata_s  = DATA_W'(ex_wb.pc_contents);
      end
      default: begin
        is_mem_s = 1'b0;
      end
    endcase
  end

  // Stage sequencer: accept, run the memory handshake, and strobe the record to writeback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      ex_ready_r  <= 1'b1;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      exwb_r      <= '0;
      can_wb_r    <= 1'b0;
      store_act_r <= 1'b0;
      mem_err_r   <= 1'b0;
      cnt_r       <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_OUT: begin
          can_wb_r    <= 1'b0;
          store_act_r <= 1'b0;
          if (transfer_s) begin
            exwb_r <= ex_wb;
            if (is_mem_s) begin
              state_r     <= ST_MEM;
              ex_ready_r  <= 1'b0;
              mem_req_r   <= 1'b1;
              mem_we_r    <= is_we_s;
              mem_addr_r  <= addr_s;
              mem_wdata_r <= wdata_s;
              cnt_r       <= 8'd0;
            end else begin
              state_r  <= ST_OUT;
              can_wb_r <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            if (!mem_we_r) begin
              exwb_r.alu_result <= 64'(mem_rdata);
            end
            state_r     <= ST_OUT;
            ex_ready_r  <= 1'b1;
            mem_req_r   <= 1'b0;
            can_wb_r    <= 1'b1;
            store_act_r <= mem_we_r;
          end else if (timeout_s) begin
            // abandon the access but still retire the record so the pipeline keeps moving
            mem_err_r   <= 1'b1;
            state_r     <= ST_OUT;
            ex_ready_r  <= 1'b1;
            mem_req_r   <= 1'b0;
            can_wb_r    <= 1'b1;
            store_act_r <= 1'b0;
          end else begin
            cnt_r <= cnt_nxt_s;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          ex_ready_r  <= 1'b1;
          mem_req_r   <= 1'b0;
          can_wb_r    <= 1'b0;
          store_act_r <= 1'b0;
        end
      endcase
    end
  end

  assign ex_ready              = ex_ready_r;
  assign mem_req               = mem_req_r;
  assign mem_we                = mem_we_r;
  assign mem_addr              = mem_addr_r;
  assign mem_wdata             = mem_wdata_r;
  assign exwb                  = exwb_r;
  assign can_writeback         = can_wb_r;
  assign store_memstage_active = store_act_r;
  assign mem_err               = mem_err_r;

endmodule

// File: tb/tb_mod_memstage.sv
// Bench for mod_memstage: directed vector table, hand-written corner sequences, and a
// randomized run checked cycle by cycle against a transaction-level model.
module tb_mod_memstage;
  import mod_memstage_pkg::*;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  ex_wb_t      ex_wb;
  logic [63:0] ex_mem_addr;
  logic [63:0] ex_store_data;
  logic [63:0] rsp_value;
  logic        flush;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  ex_wb_t      exwb;
  logic        can_writeback;
  logic        store_memstage_active;
  logic        mem_err;

  always #5 clk = ~clk;

  mod_memstage #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wb(ex_wb),
    .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data), .rsp_value(rsp_value),
    .flush(flush), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .exwb(exwb),
    .can_writeback(can_writeback), .store_memstage_active(store_memstage_active),
    .mem_err(mem_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ex_wb_t mk_rec(input logic [7:0] op, input logic [63:0] alu, input logic [63:0] pc);
    ex_wb_t r;
    r.opcode      = op;
    r.alu_result  = alu;
    r.alu_result2 = {$urandom, $urandom};
    r.reg_byte    = 8'($urandom);
    r.rm_byte     = 8'($urandom);
    r.pc_contents = pc;
    r.sim_end     = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Reference rules: which opcodes touch memory, direction, address and write data.
  function automatic void model_req(input ex_wb_t r, input logic [63:0] ea, input logic [63:0] sd,
                                    input logic [63:0] rsp, output bit m, output bit w,
                                    output logic [63:0] a, output logic [63:0] d);
    m = 1'b1; w = 1'b1; a = ea; d = sd;
    if (r.opcode == 8'd137) begin
      m = 1'b1;
    end else if (r.opcode == 8'd139) begin
      w = 1'b0;
    end else if (r.opcode >= 8'h50 && r.opcode <= 8'h57) begin
      a = rsp - 64'd8;
    end else if (r.opcode >= 8'h58 && r.opcode <= 8'h5F) begin
      w = 1'b0; a = rsp;
    end else if (r.opcode == 8'hE8 || r.opcode == 8'hFF) begin
      a = rsp - 64'd8; d = r.pc_contents;
    end else begin
      m = 1'b0;
    end
  endfunction

  typedef struct {
    logic [7:0]  op;
    logic [63:0] alu;
    logic [63:0] pc;
    logic [63:0] rsp;
    logic [63:0] addr;
    logic [63:0] sdata;
    int          ncyc;
    logic [63:0] rdata;
    logic        x_mem;
    logic        x_we;
    logic [63:0] x_addr;
    logic [63:0] x_wdata;
    logic [63:0] x_alu;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input int idx, input vec_t v);
    ex_wb_t r, xr;
    r = mk_rec(v.op, v.alu, v.pc);
    xr = r;
    xr.alu_result = v.x_alu;
    ex_wb = r; ex_mem_addr = v.addr; ex_store_data = v.sdata; rsp_value = v.rsp; ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    ex_wb = mk_rec(8'h00, 64'hBAD, 64'hBAD);
    ex_mem_addr = 64'hBAD0; ex_store_data = 64'hBAD1; rsp_value = 64'hBAD2;
    if (v.x_mem) begin
      for (int k = 0; k < v.ncyc; k++) begin
        chk($sformatf("v%0d_req", idx), 256'(mem_req), 256'(1'b1));
        chk($sformatf("v%0d_ready", idx), 256'(ex_ready), 256'(1'b0));
        chk($sformatf("v%0d_we", idx), 256'(mem_we), 256'(v.x_we));
        chk($sformatf("v%0d_addr", idx), 256'(mem_addr), 256'(v.x_addr));
        if (v.x_we) chk($sformatf("v%0d_wdata", idx), 256'(mem_wdata), 256'(v.x_wdata));
        chk($sformatf("v%0d_cw_early", idx), 256'(can_writeback), 256'(1'b0));
        if (k == v.ncyc - 1) begin
          mem_ack = 1'b1; mem_rdata = v.rdata;
        end
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 64'hF00D;
      end
    end
    chk($sformatf("v%0d_cw", idx), 256'(can_writeback), 256'(1'b1));
    chk($sformatf("v%0d_exwb", idx), 256'(exwb), 256'(xr));
    chk($sformatf("v%0d_store", idx), 256'(store_memstage_active), 256'(v.x_we));
    chk($sformatf("v%0d_req_off", idx), 256'(mem_req), 256'(1'b0));
    chk($sformatf("v%0d_ready_out", idx), 256'(ex_ready), 256'(1'b1));
    @(negedge clk);
    chk($sformatf("v%0d_cw_once", idx), 256'(can_writeback), 256'(1'b0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ex_wb_t r, r2, exp_rec, p_rec;
    bit pend, exp_cw, exp_st, p_we, m, w;
    logic [63:0] p_addr, p_wdata, a, d;
    logic [7:0] op;
    int n;

    vecs[0] = '{8'h01, 64'd5, 64'h100, 64'h0, 64'h0, 64'h0, 0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'd5};
    vecs[1] = '{8'd139, 64'h11, 64'h104, 64'h500, 64'h1000, 64'h99, 3, 64'hDEADBEEF, 1'b1, 1'b0, 64'h1000, 64'h0, 64'hDEADBEEF};
    vecs[2] = '{8'h50, 64'h77, 64'h108, 64'h2000, 64'h4444, 64'hAA, 1, 64'h5555, 1'b1, 1'b1, 64'h1FF8, 64'hAA, 64'h77};
    vecs[3] = '{8'h5B, 64'h22, 64'h10C, 64'h3000, 64'h8, 64'h0, 2, 64'h1234, 1'b1, 1'b0, 64'h3000, 64'h0, 64'h1234};
    vecs[4] = '{8'hFF, 64'h33, 64'h4010, 64'h0, 64'h8, 64'h66, 2, 64'h0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h4010, 64'h33};
    vecs[5] = '{8'd137, 64'h44, 64'h110, 64'h9000, 64'h8000, 64'hCAFE, 1, 64'h7, 1'b1, 1'b1, 64'h8000, 64'hCAFE, 64'h44};
    vecs[6] = '{8'h4F, 64'hFFFF_FFFF_FFFF_FFFF, 64'h114, 64'h100, 64'h0, 64'h0, 0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[7] = '{8'h60, 64'h0, 64'h118, 64'h100, 64'h0, 64'h0, 0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0};
    vecs[8] = '{8'h8A, 64'h3, 64'h11C, 64'h100, 64'h40, 64'h50, 0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h3};

    reset = 1'b0; ex_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = 64'h0;
    ex_wb = '0; ex_mem_addr = 64'h0; ex_store_data = 64'h0; rsp_value = 64'h0;
    repeat (2) @(negedge clk);
    chk("rst_req", 256'(mem_req), 256'(1'b0));
    chk("rst_cw", 256'(can_writeback), 256'(1'b0));
    chk("rst_err", 256'(mem_err), 256'(1'b0));
    chk("rst_exwb", 256'(exwb), 256'(0));
    chk("rst_addr", 256'(mem_addr), 256'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", 256'(ex_ready), 256'(1'b1));

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Call, with an ALU op waiting behind it while memory is busy.
    r = mk_rec(8'hE8, 64'h5, 64'h4010);
    r2 = mk_rec(8'h01, 64'h9, 64'h4015);
    ex_wb = r; rsp_value = 64'h100; ex_valid = 1'b1;
    @(negedge clk);
    ex_wb = r2;
    chk("t4_ready0", 256'(ex_ready), 256'(1'b0));
    chk("t4_req", 256'(mem_req), 256'(1'b1));
    chk("t4_addr", 256'(mem_addr), 256'(64'hF8));
    chk("t4_wdata", 256'(mem_wdata), 256'(64'h4010));
    @(negedge clk);
    chk("t4_ready0b", 256'(ex_ready), 256'(1'b0));
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("t4_call_cw", 256'(can_writeback), 256'(1'b1));
    chk("t4_call_exwb", 256'(exwb), 256'(r));
    chk("t4_call_store", 256'(store_memstage_active), 256'(1'b1));
    @(negedge clk);
    ex_valid = 1'b0;
    chk("t4_alu_cw", 256'(can_writeback), 256'(1'b1));
    chk("t4_alu_exwb", 256'(exwb), 256'(r2));
    chk("t4_alu_store", 256'(store_memstage_active), 256'(1'b0));
    @(negedge clk);
    chk("t4_idle", 256'(can_writeback), 256'(1'b0));

    // flush blocks acceptance in IDLE; then two ALU ops back to back.
    r = mk_rec(8'h01, 64'hA1, 64'h200);
    r2 = mk_rec(8'h02, 64'hB2, 64'h204);
    ex_wb = r; ex_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("fl_block", 256'(can_writeback), 256'(1'b0));
    flush = 1'b0;
    @(negedge clk);
    ex_wb = r2;
    chk("b2b_first", 256'(exwb), 256'(r));
    chk("b2b_first_cw", 256'(can_writeback), 256'(1'b1));
    @(negedge clk);
    ex_valid = 1'b0;
    chk("b2b_second", 256'(exwb), 256'(r2));
    chk("b2b_second_cw", 256'(can_writeback), 256'(1'b1));
    @(negedge clk);
    chk("b2b_idle", 256'(can_writeback), 256'(1'b0));

    // Store that never gets acked, with flush held during the wait.
    r = mk_rec(8'd137, 64'hABC, 64'h300);
    ex_wb = r; ex_mem_addr = 64'h7000; ex_store_data = 64'h55; ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0; flush = 1'b1;
    n = 0;
    while (mem_req === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    flush = 1'b0;
    chk("t5_req_cycles", 256'(n), 256'(TIMEOUT));
    chk("t5_cw", 256'(can_writeback), 256'(1'b1));
    chk("t5_err", 256'(mem_err), 256'(1'b1));
    chk("t5_exwb", 256'(exwb), 256'(r));
    @(negedge clk);
    chk("t5_cw_once", 256'(can_writeback), 256'(1'b0));
    run_vec(100, vecs[0]);
    chk("t5_err_sticky", 256'(mem_err), 256'(1'b1));

    // Asynchronous reset in the middle of a load.
    ex_wb = mk_rec(8'd139, 64'h1, 64'h400); ex_mem_addr = 64'h1234; ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("t6_req_before", 256'(mem_req), 256'(1'b1));
    #2 reset = 1'b0;
    #1;
    chk("t6_req_async", 256'(mem_req), 256'(1'b0));
    chk("t6_err_clr", 256'(mem_err), 256'(1'b0));
    chk("t6_exwb_clr", 256'(exwb), 256'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_ready", 256'(ex_ready), 256'(1'b1));
    chk("t6_req_idle", 256'(mem_req), 256'(1'b0));
    chk("t6_cw_idle", 256'(can_writeback), 256'(1'b0));

    // Randomized traffic against the transaction-level model.
    pend = 1'b0; exp_cw = 1'b0; exp_st = 1'b0; exp_rec = '0;
    p_rec = '0; p_we = 1'b0; p_addr = 64'h0; p_wdata = 64'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_cw", 256'(can_writeback), 256'(exp_cw));
      if (exp_cw) begin
        chk("rnd_exwb", 256'(exwb), 256'(exp_rec));
        chk("rnd_store", 256'(store_memstage_active), 256'(exp_st));
      end
      chk("rnd_ready", 256'(ex_ready), 256'(!pend));
      chk("rnd_req", 256'(mem_req), 256'(pend));
      if (pend) begin
        chk("rnd_we", 256'(mem_we), 256'(p_we));
        chk("rnd_addr", 256'(mem_addr), 256'(p_addr));
        if (p_we) chk("rnd_wdata", 256'(mem_wdata), 256'(p_wdata));
      end
      chk("rnd_err", 256'(mem_err), 256'(1'b0));

      case ($urandom_range(0, 6))
        0: op = 8'd137;
        1: op = 8'd139;
        2: op = 8'h50 + 8'($urandom_range(0, 7));
        3: op = 8'h58 + 8'($urandom_range(0, 7));
        4: op = ($urandom_range(0, 1) == 0) ? 8'hE8 : 8'hFF;
        default: op = 8'($urandom);
      endcase
      ex_wb = mk_rec(op, {$urandom, $urandom}, {$urandom, $urandom});
      ex_mem_addr = {$urandom, $urandom};
      ex_store_data = {$urandom, $urandom};
      rsp_value = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 15)) : {$urandom, $urandom};
      mem_rdata = {$urandom, $urandom};
      ex_valid = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 3) == 0);
      exp_cw = 1'b0;
      if (pend) begin
        mem_ack = ($urandom_range(0, 2) == 0);
        if (mem_ack) begin
          exp_cw = 1'b1; exp_rec = p_rec; exp_st = p_we;
          if (!p_we) exp_rec.alu_result = mem_rdata;
          pend = 1'b0;
        end
      end else begin
        mem_ack = ($urandom_range(0, 3) == 0);
        if (ex_valid && !flush) begin
          model_req(ex_wb, ex_mem_addr, ex_store_data, rsp_value, m, w, a, d);
          if (m) begin
            pend = 1'b1; p_rec = ex_wb; p_we = w; p_addr = a; p_wdata = d;
          end else begin
            exp_cw = 1'b1; exp_rec = ex_wb; exp_st = 1'b0;
          end
        end
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
